// File: rtl/pulse_scheduler.sv
// Periodic pulse generator that hands its single slot per period to one of N
// requesters, chosen round-robin, with a programmable period and enable gating.
module pulse_scheduler #(
  parameter int N              = 4,
  parameter int CNT_W          = 4,
  parameter int DEFAULT_PERIOD = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             period_load,
  input  logic [CNT_W-1:0] period_in,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             busy
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  // A zero period would never wrap, so it is clamped to 1 everywhere it enters.
  localparam logic [CNT_W-1:0] RESET_PERIOD =
    (DEFAULT_PERIOD < 1) ? ONE : CNT_W'(DEFAULT_PERIOD);
  localparam logic [N-1:0] GRANT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;
  logic             tick_q, tick_d;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] ptr_after_pick;

  // Scan offsets from the far end so the nearest request at/after ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'(idx);
      end
    end
  end

  assign ptr_after_pick = (pick_idx == PTR_W'(N - 1)) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_d  = enable ? ST_RUN : ST_IDLE;
    cnt_d    = cnt_q;
    period_d = period_q;
    ptr_d    = ptr_q;
    tick_d   = 1'b0;
    grant_d  = '0;
    if (period_load) begin
      period_d = (period_in == '0) ? ONE : period_in;
      cnt_d    = '0;
    end else if (enable) begin
      if (cnt_q == period_q - ONE) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pick_valid) begin
          grant_d = GRANT_ONE << pick_idx;
          ptr_d   = ptr_after_pick;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= RESET_PERIOD;
      ptr_q    <= '0;
      tick_q   <= 1'b0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ptr_q    <= ptr_d;
      tick_q   <= tick_d;
      grant_q  <= grant_d;
    end
  end

  assign grant  = grant_q;
  assign tick   = tick_q;
  assign period = period_q;
  assign busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed checks of the pulse scheduler: periodic tick, round-robin grants,
// period reload, enable gating and mid-period reset.
module tb_pulse_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       period_load;
  logic [3:0] period_in;
  logic [3:0] req;
  logic [3:0] grant;
  logic       tick;
  logic [3:0] period;
  logic       busy;

  int checks = 0;
  int errors = 0;

  pulse_scheduler #(.N(4), .CNT_W(4), .DEFAULT_PERIOD(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .period_load (period_load),
    .period_in   (period_in),
    .req         (req),
    .grant       (grant),
    .tick        (tick),
    .period      (period),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; period_load = 1'b0; period_in = 4'd0; req = 4'd0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; period_load = 1'b1; period_in = 4'd7; req = 4'b1111;
    step();
    step();
    checks++;
    if (tick !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || period !== 4'd3) begin
      errors++;
      $display("FAIL reset: tick=%b grant=%b busy=%b period=%0d, want 0 0000 0 3",
               tick, grant, busy, period);
    end
    reset = 1'b0; enable = 1'b0; period_load = 1'b0; req = 4'd0;
    $display("reset: period=%0d busy=%b", period, busy);
  endtask

  task automatic test_basic_tick();
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      checks++;
      if (tick !== ((c % 3) == 0) || grant !== 4'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_tick c=%0d: tick=%b grant=%b busy=%b, want tick=%b grant=0000 busy=1",
                 c, tick, grant, busy, (c % 3) == 0);
      end
    end
    $display("basic_tick: 9 cycles checked");
  endtask

  task automatic test_sparse();
    logic [3:0] exp [3];
    exp[0] = 4'b0100; exp[1] = 4'b0001; exp[2] = 4'b0100;
    do_reset();
    enable = 1'b1; req = 4'b0001;
    step(); step(); step();
    checks++;
    if (tick !== 1'b1 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL sparse_setup: tick=%b grant=%b, want 1 0001", tick, grant);
    end
    req = 4'b0101;
    for (int t = 0; t < 3; t++) begin
      step(); step(); step();
      checks++;
      if (tick !== 1'b1 || grant !== exp[t]) begin
        errors++;
        $display("FAIL sparse t=%0d: tick=%b grant=%b, want 1 %b", t, tick, grant, exp[t]);
      end
      $display("sparse tick %0d: grant=%b", t, grant);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp [5];
    exp[0] = 4'b0001; exp[1] = 4'b0010; exp[2] = 4'b0100; exp[3] = 4'b1000; exp[4] = 4'b0001;
    do_reset();
    enable = 1'b1; req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 2; c++) begin
        step();
        checks++;
        if (tick !== 1'b0 || grant !== 4'b0) begin
          errors++;
          $display("FAIL rr_gap t=%0d c=%0d: tick=%b grant=%b, want 0 0000", t, c, tick, grant);
        end
      end
      step();
      checks++;
      if (tick !== 1'b1 || grant !== exp[t]) begin
        errors++;
        $display("FAIL rr t=%0d: tick=%b grant=%b, want 1 %b", t, tick, grant, exp[t]);
      end
      $display("rr tick %0d: grant=%b", t, grant);
    end
  endtask

  task automatic test_period_load();
    do_reset();
    enable = 1'b1;
    step();
    period_load = 1'b1; period_in = 4'd5;
    step();
    period_load = 1'b0;
    checks++;
    if (tick !== 1'b0 || period !== 4'd5) begin
      errors++;
      $display("FAIL load5: tick=%b period=%0d, want 0 5", tick, period);
    end
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if (tick !== (c == 5)) begin
        errors++;
        $display("FAIL load5_run c=%0d: tick=%b, want %b", c, tick, c == 5);
      end
    end
    period_load = 1'b1; period_in = 4'd0;
    step();
    period_load = 1'b0;
    checks++;
    if (tick !== 1'b0 || period !== 4'd1) begin
      errors++;
      $display("FAIL load0: tick=%b period=%0d, want 0 1", tick, period);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (tick !== 1'b1) begin
        errors++;
        $display("FAIL period1 c=%0d: tick=%b, want 1", c, tick);
      end
    end
    $display("period_load: period=%0d", period);
  endtask

  task automatic test_enable_gap();
    do_reset();
    enable = 1'b1; req = 4'b1111;
    step();
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (tick !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL gap c=%0d: tick=%b grant=%b busy=%b, want 0 0000 0", c, tick, grant, busy);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (tick !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resume1: tick=%b busy=%b, want 0 1", tick, busy);
    end
    step();
    checks++;
    if (tick !== 1'b1 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL resume2: tick=%b grant=%b, want 1 0001", tick, grant);
    end
    $display("enable_gap: resumed grant=%b", grant);
  endtask

  task automatic test_enable_priority();
    do_reset();
    enable = 1'b1; req = 4'b0010;
    step(); step();
    enable = 1'b0;
    step();
    checks++;
    if (tick !== 1'b0 || grant !== 4'b0) begin
      errors++;
      $display("FAIL enable_prio: tick=%b grant=%b, want 0 0000", tick, grant);
    end
    enable = 1'b1;
    step();
    checks++;
    if (tick !== 1'b1 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL enable_prio_resume: tick=%b grant=%b, want 1 0010", tick, grant);
    end
    $display("enable_priority: grant=%b", grant);
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; req = 4'b1111;
    period_load = 1'b1; period_in = 4'd2;
    step();
    period_load = 1'b0;
    step(); step();
    checks++;
    if (tick !== 1'b1 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_pre: tick=%b grant=%b, want 1 0001", tick, grant);
    end
    step();
    reset = 1'b1; req = 4'b1000;
    step();
    reset = 1'b0;
    checks++;
    if (tick !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || period !== 4'd3) begin
      errors++;
      $display("FAIL reset_mid: tick=%b grant=%b busy=%b period=%0d, want 0 0000 0 3",
               tick, grant, busy, period);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (tick !== (c == 3) || grant !== ((c == 3) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL reset_mid_run c=%0d: tick=%b grant=%b, want %b %b",
                 c, tick, grant, c == 3, (c == 3) ? 4'b1000 : 4'b0000);
      end
    end
    $display("reset_mid: first grant=%b", grant);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; period_load = 1'b0; period_in = 4'd0; req = 4'd0;
    test_reset();
    test_basic_tick();
    test_sparse();
    test_round_robin();
    test_period_load();
    test_enable_gap();
    test_enable_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
